analog_switch_seq: RTL and testbench

Parametrised sequencer for banks of 74HC4053-class analog switches on the calibration front end. Accepts a select code per channel through a valid/ready handshake. Drives the switch enable and select lines with a break-before-make sequence followed by a settling interval, so the switch never shorts two inputs. Reports when the new path is settled. Sits between the calibration controller and the external switch pins.

---
 rtl/analog_switch_seq_if.sv | 10 +
 rtl/analog_switch_seq.sv | 104 ++++++++++
 tb/tb_analog_switch_seq.sv | 100 ++++++++++
 3 files changed

// File: rtl/analog_switch_seq_if.sv
// analog_switch_seq_if: request handshake and switch-pin bundle between calibration controller and sequencer.
interface analog_switch_seq_if #(parameter int CH = 3, parameter int SELW = 1);
  logic                 req_valid, req_ready, off_req, scan_en;
  logic                 sw_en_n, settled, busy;
  logic [CH*SELW-1:0]   req_sel, sw_sel;
  modport master (output req_valid, req_sel, off_req, scan_en,
                  input  req_ready, sw_en_n, sw_sel, settled, busy);
  modport slave  (input  req_valid, req_sel, off_req, scan_en,
                  output req_ready, sw_en_n, sw_sel, settled, busy);
endinterface

// File: rtl/analog_switch_seq.sv
// analog_switch_seq: break-before-make analog switch sequencer; define SWITCH_SCAN_EN for dwell-timed auto-scan.
module analog_switch_seq #(
  parameter int CH         = 3,
  parameter int SELW       = 1,
  parameter int BBM_CYC    = 4,
  parameter int SETTLE_CYC = 16,
  parameter int DWELL_CYC  = 64,
  parameter int CNTW       = 8
) (
  input logic               clk,
  input logic               rst,
  analog_switch_seq_if.slave bus
);
  localparam int W = CH*SELW;
  if (BBM_CYC < 1 || SETTLE_CYC < 1 || DWELL_CYC < 1 ||
      BBM_CYC > 2**CNTW || SETTLE_CYC > 2**CNTW || DWELL_CYC > 2**CNTW) begin : g_bad_param
    $error("analog_switch_seq: interval parameters must be >= 1 and fit the timer");
  end
  typedef enum logic [1:0] {IDLE, BREAK, SETTLE, HOLD} state_t;
  state_t          state_q, state_d;
  logic [CNTW-1:0] timer_q, timer_d;
  logic [W-1:0]    sw_sel_q, sw_sel_d, pending_q, pending_d;
  logic            sw_en_n_q, sw_en_n_d, settled_q, settled_d;
  logic            ready, accept;
  assign ready         = (state_q == IDLE || state_q == HOLD) && !bus.off_req && !rst;
  assign accept        = bus.req_valid && ready;
  assign bus.req_ready = ready;
  assign bus.busy      = state_q == BREAK || state_q == SETTLE;
  assign bus.sw_en_n   = sw_en_n_q;
  assign bus.sw_sel    = sw_sel_q;
  assign bus.settled   = settled_q;
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    sw_sel_d  = sw_sel_q;
    pending_d = pending_q;
    sw_en_n_d = sw_en_n_q;
    settled_d = settled_q;
    if (bus.off_req) begin
      state_d   = IDLE;
      sw_en_n_d = 1'b1;
      settled_d = 1'b0;
      timer_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          sw_sel_d  = bus.req_sel;
          sw_en_n_d = 1'b0;
          state_d   = SETTLE;
          timer_d   = CNTW'(SETTLE_CYC-1);
        end
        BREAK: if (timer_q == '0) begin
          sw_sel_d  = pending_q;
          sw_en_n_d = 1'b0;
          state_d   = SETTLE;
          timer_d   = CNTW'(SETTLE_CYC-1);
        end else timer_d = timer_q - CNTW'(1);
        SETTLE: if (timer_q == '0) begin
          settled_d = 1'b1;
          state_d   = HOLD;
        end else timer_d = timer_q - CNTW'(1);
        default: begin
          timer_d = '0;
          if (accept && bus.req_sel != sw_sel_q) begin
            pending_d = bus.req_sel;
            sw_en_n_d = 1'b1;
            settled_d = 1'b0;
            state_d   = BREAK;
            timer_d   = CNTW'(BBM_CYC-1);
          end
`ifdef SWITCH_SCAN_EN
          // The idle timer doubles as the dwell counter while holding a path.
          else if (!accept && bus.scan_en) begin
            if (timer_q == CNTW'(DWELL_CYC-1)) begin
              pending_d = sw_sel_q + W'(1);
              sw_en_n_d = 1'b1;
              settled_d = 1'b0;
              state_d   = BREAK;
              timer_d   = CNTW'(BBM_CYC-1);
            end else timer_d = timer_q + CNTW'(1);
          end
`endif
        end
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      sw_sel_q  <= '0;
      pending_q <= '0;
      sw_en_n_q <= 1'b1;
      settled_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      sw_sel_q  <= sw_sel_d;
      pending_q <= pending_d;
      sw_en_n_q <= sw_en_n_d;
      settled_q <= settled_d;
    end
  end
endmodule

// File: tb/tb_analog_switch_seq.sv
// tb_analog_switch_seq: timestamp-based reference model feeds a per-cycle scoreboard checked at negedge.
module tb_analog_switch_seq;
  localparam int CH = 3, SELW = 1, W = CH*SELW;
  localparam int BBM = 4, SET = 16, DWELL = 64;
  typedef struct {
    logic         en_n;
    logic [W-1:0] sel;
    logic         settled;
    logic         busy;
    logic         rdy_base;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  int   n_chk = 0, n_fail = 0;
  exp_t sbq[$];
  analog_switch_seq_if #(.CH(CH), .SELW(SELW)) bus ();
  analog_switch_seq #(.CH(CH), .SELW(SELW), .BBM_CYC(BBM), .SETTLE_CYC(SET),
                      .DWELL_CYC(DWELL), .CNTW(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // Reference model: phases are tracked as absolute edge numbers at which events fall due.
  int           e = 0, mode = 0, break_end = -1, settle_at = -1, dwell = 0;
  logic         m_on = 1'b0, m_settled = 1'b0, acc;
  logic [W-1:0] m_sel = '0, m_pending = '0;
  task automatic start_break(input logic [W-1:0] code);
    m_pending = code; m_on = 1'b0; m_settled = 1'b0; mode = 1;
    break_end = e + BBM; settle_at = e + BBM + SET;
  endtask
  always @(posedge clk) begin
    e++;
    if (rst || bus.off_req) begin
      mode = 0; m_on = 1'b0; m_settled = 1'b0; break_end = -1; settle_at = -1; dwell = 0;
      if (rst) m_sel = '0;
    end else begin
      acc = bus.req_valid && mode != 1;
      if (acc && mode == 0) begin
        m_sel = bus.req_sel; m_on = 1'b1; mode = 1; settle_at = e + SET;
      end else if (acc && bus.req_sel != m_sel) start_break(bus.req_sel);
`ifdef SWITCH_SCAN_EN
      if (mode == 2 && bus.scan_en && !acc) begin
        dwell++;
        if (dwell == DWELL) begin dwell = 0; start_break(m_sel + 1'b1); end
      end else dwell = 0;
`endif
      if (break_end == e) begin m_sel = m_pending; m_on = 1'b1; end
      if (settle_at == e) begin m_settled = 1'b1; mode = 2; end
    end
    sbq.push_back('{!m_on, m_sel, m_settled, mode == 1, mode != 1});
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  always @(negedge clk) begin
    exp_t x;
    if (sbq.size() != 0) begin
      x = sbq.pop_front();
      if (rst) x = '{1'b1, '0, 1'b0, 1'b0, 1'b0};
      chk("sw_en_n", 32'(bus.sw_en_n), 32'(x.en_n));
      chk("sw_sel", 32'(bus.sw_sel), 32'(x.sel));
      chk("settled", 32'(bus.settled), 32'(x.settled));
      chk("busy", 32'(bus.busy), 32'(x.busy));
      chk("req_ready", 32'(bus.req_ready), 32'(x.rdy_base && !bus.off_req && !rst));
    end
  end
  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask
  task automatic req(input logic [W-1:0] code);
    bus.req_valid = 1'b1; bus.req_sel = code; step(); bus.req_valid = 1'b0;
  endtask
  initial begin
    bus.req_valid = 1'b0; bus.req_sel = '0; bus.off_req = 1'b0; bus.scan_en = 1'b0;
    step(3); rst = 1'b0; step();
    req(3'b101); step(20);
    req(3'b010); step(25);
    req(3'b010); step(3);
    req(3'b101); step();
    bus.off_req = 1'b1; bus.req_valid = 1'b1; bus.req_sel = 3'b011; step(2);
    bus.off_req = 1'b0; bus.req_valid = 1'b0; step(3);
    req(3'b110); step(5);
    rst = 1'b1; step(2); rst = 1'b0; step(2);
`ifdef SWITCH_SCAN_EN
    req(3'b111); step(20); bus.scan_en = 1'b1; step(200); bus.scan_en = 1'b0; step(2);
`endif
    for (int i = 0; i < 4000; i++) begin
      bus.req_valid = ($urandom % 4) == 0;
      bus.req_sel   = W'($urandom);
      bus.off_req   = ($urandom % 60) == 0;
      if (($urandom % 50) == 0) bus.scan_en = ~bus.scan_en;
      rst = ($urandom % 700) == 0;
      step();
    end
    rst = 1'b0; bus.req_valid = 1'b0; bus.off_req = 1'b0; step(3);
    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
